// File: rtl/cdc_traffic_checker_if.sv
// Command/response FIFO port bundle between the traffic checker and the FIFOs.
//   cmd_wr_en    : command FIFO write strobe (checker -> FIFO)
//   cmd_wr_data  : command word (checker -> FIFO)
//   cmd_full     : command FIFO full flag (FIFO -> checker)
//   resp_rd_en   : response FIFO read strobe (checker -> FIFO)
//   resp_rd_data : response word, valid one cycle after resp_rd_en (FIFO -> checker)
//   resp_empty   : response FIFO empty flag (FIFO -> checker)
interface cdc_traffic_checker_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cmd_wr_en;
    logic [DATA_WIDTH-1:0] cmd_wr_data;
    logic                  cmd_full;
    logic                  resp_rd_en;
    logic [DATA_WIDTH-1:0] resp_rd_data;
    logic                  resp_empty;

    modport master (
        output cmd_wr_en,
        output cmd_wr_data,
        input  cmd_full,
        output resp_rd_en,
        input  resp_rd_data,
        input  resp_empty
    );

    modport slave (
        input  cmd_wr_en,
        input  cmd_wr_data,
        output cmd_full,
        input  resp_rd_en,
        output resp_rd_data,
        output resp_empty
    );
endinterface

// File: rtl/cdc_traffic_checker.sv
// Command/response traffic checker for the CDC FIFO pair. Issues NUM_TXN patterned
// commands, pops NUM_TXN responses, checks each against a regenerated expected word
// (command + RESP_ADD) and reports pass/fail, error statistics and watchdog timeout.
//   clk, rst      : sole clock, synchronous active-high reset
//   start         : pulse that begins a run (ignored while running)
//   mode_lfsr     : 0 = incrementing pattern, 1 = LFSR pattern; sampled on start
//   bus           : command write / response read FIFO ports (master side)
//   busy, done    : running / finished
//   success       : no mismatches and no timeout (valid with done)
//   timeout       : watchdog fired during this run
//   err_count     : saturating mismatch count
//   first_err_idx : index of the first mismatching response
module cdc_traffic_checker #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_TXN         = 16,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned RESP_ADD        = 1,
    parameter logic [31:0] LFSR_SEED       = 32'h0000_0001,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode_lfsr,
    cdc_traffic_checker_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  success,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [CNT_W-1:0]      first_err_idx
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic             mode_q;
    logic [CNT_W-1:0] issued_q, popped_q, checked_q;
    logic [31:0]      cmd_lfsr_q, exp_lfsr_q;
    logic [WD_W-1:0]  wd_q;
    logic             rd_valid_q;
    logic             timeout_q;
    logic [15:0]      err_q;
    logic [CNT_W-1:0] first_q;

    logic                  run;
    logic [CNT_W-1:0]      outstanding;
    logic [DATA_WIDTH-1:0] exp_word;
    logic [DATA_WIDTH-1:0] resp_expected;
    logic                  mismatch;
    logic                  wd_fire;

    // Fibonacci LFSR, taps 31/21/1/0, shifted left with feedback into bit 0.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    always_comb begin
        run         = (state_q == StRun);
        outstanding = issued_q - popped_q;

        bus.cmd_wr_en   = run && (issued_q < CNT_W'(NUM_TXN)) && !bus.cmd_full &&
                          (outstanding < CNT_W'(MAX_OUTSTANDING));
        bus.cmd_wr_data = mode_q ? cmd_lfsr_q[DATA_WIDTH-1:0] : DATA_WIDTH'(issued_q);
        bus.resp_rd_en  = run && (popped_q < CNT_W'(NUM_TXN)) && !bus.resp_empty;

        exp_word      = mode_q ? exp_lfsr_q[DATA_WIDTH-1:0] : DATA_WIDTH'(checked_q);
        resp_expected = exp_word + DATA_WIDTH'(RESP_ADD);
        mismatch      = (bus.resp_rd_data != resp_expected);

        // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a strobe.
        wd_fire = run && !bus.cmd_wr_en && !bus.resp_rd_en &&
                  (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

        busy          = run;
        done          = (state_q == StDone);
        success       = done && (err_q == 16'd0) && !timeout_q;
        timeout       = timeout_q;
        err_count     = err_q;
        first_err_idx = first_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            issued_q   <= '0;
            popped_q   <= '0;
            checked_q  <= '0;
            cmd_lfsr_q <= '0;
            exp_lfsr_q <= '0;
            wd_q       <= '0;
            rd_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= '0;
            first_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StRun;
                        mode_q     <= mode_lfsr;
                        issued_q   <= '0;
                        popped_q   <= '0;
                        checked_q  <= '0;
                        cmd_lfsr_q <= LFSR_SEED;
                        exp_lfsr_q <= LFSR_SEED;
                        wd_q       <= '0;
                        rd_valid_q <= 1'b0;
                        timeout_q  <= 1'b0;
                        err_q      <= '0;
                        first_q    <= '0;
                    end
                end
                StRun: begin
                    if (bus.cmd_wr_en) begin
                        issued_q   <= issued_q + 1'b1;
                        cmd_lfsr_q <= lfsr_next(cmd_lfsr_q);
                    end
                    if (bus.resp_rd_en) begin
                        popped_q <= popped_q + 1'b1;
                    end
                    rd_valid_q <= bus.resp_rd_en;

                    if (bus.cmd_wr_en || bus.resp_rd_en) begin
                        wd_q <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end

                    // A check landing on the watchdog cycle is dropped with the run.
                    if (rd_valid_q && !wd_fire) begin
                        checked_q  <= checked_q + 1'b1;
                        exp_lfsr_q <= lfsr_next(exp_lfsr_q);
                        if (mismatch) begin
                            if (err_q != 16'hFFFF) begin
                                err_q <= err_q + 16'd1;
                            end
                            if (err_q == 16'd0) begin
                                first_q <= checked_q;
                            end
                        end
                    end

                    if (wd_fire) begin
                        timeout_q  <= 1'b1;
                        rd_valid_q <= 1'b0;
                        state_q    <= StDone;
                    end else if (rd_valid_q && (checked_q == CNT_W'(NUM_TXN - 1))) begin
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_cdc_traffic_checker.sv
// Bench for cdc_traffic_checker: a FIFO/loopback responder with randomized stalls,
// and a per-cycle compare process against a pattern/scoreboard model.
module tb_cdc_traffic_checker;
    localparam int DW = 32;
    localparam int NT = 16;
    localparam int CW = 16;
    localparam int MO = 8;
    localparam int TO = 4096;
    localparam int CMD_DEPTH = 4;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic mode_lfsr = 1'b0;
    logic busy, done, success, timeout;
    logic [15:0] err_count;
    logic [CW-1:0] first_err_idx;

    cdc_traffic_checker_if #(.DATA_WIDTH(DW)) bus ();

    cdc_traffic_checker #(
        .DATA_WIDTH(DW), .NUM_TXN(NT), .CNT_W(CW), .MAX_OUTSTANDING(MO),
        .RESP_ADD(1), .LFSR_SEED(SEED), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode_lfsr(mode_lfsr), .bus(bus),
        .busy(busy), .done(done), .success(success), .timeout(timeout),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    // Scenario knobs, written by the stimulus process only.
    int            lat = 10;
    bit            drop_resp = 1'b0;
    bit            rand_stall = 1'b0;
    bit            rand_full = 1'b0;
    bit            force_full = 1'b0;
    logic [NT-1:0] corrupt_mask = '0;
    bit            exp_timeout = 1'b0;
    int            pin_errs = -1;
    int            pin_first = -1;
    bit            pin_lfsr = 1'b0;
    bit            pin_inc = 1'b0;
    int            stuck_cnt = 0;

    // ---------------- FIFO + loopback responder ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic [31:0]   due;
    } cmd_t;
    cmd_t          cmdq[$];
    logic [DW-1:0] respq[$];
    cmd_t          c_tmp;
    logic [DW-1:0] w_tmp;
    int unsigned   cyc = 0;
    int            resp_idx = 0;
    logic          full_q = 1'b0;

    assign bus.cmd_full = full_q | force_full;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            cmdq.delete();
            respq.delete();
            resp_idx = 0;
            full_q <= 1'b0;
            bus.resp_empty <= 1'b1;
            bus.resp_rd_data <= '0;
        end else begin
            if (start && !busy) resp_idx = 0;
            if (bus.resp_rd_en && respq.size() > 0) bus.resp_rd_data <= respq.pop_front();
            if (bus.cmd_wr_en) cmdq.push_back({bus.cmd_wr_data, 32'(cyc + 32'(lat))});
            if (cmdq.size() > 0 && cmdq[0].due <= cyc &&
                !(rand_stall && $urandom_range(0, 3) == 0)) begin
                c_tmp = cmdq.pop_front();
                if (!drop_resp) begin
                    w_tmp = c_tmp.data + 1;
                    if (resp_idx < NT && corrupt_mask[resp_idx]) w_tmp[0] = ~w_tmp[0];
                    respq.push_back(w_tmp);
                    resp_idx++;
                end
            end
            full_q <= (cmdq.size() >= CMD_DEPTH) || (rand_full && $urandom_range(0, 3) == 0);
            bus.resp_empty <= (respq.size() == 0);
        end
    end

    // ---------------- compare process ----------------
    int            n_cmp = 0;
    int            n_fail = 0;
    int            wr_idx = 0, pop_idx = 0, chk_idx = 0;
    int            m_errs = 0, m_first = 0;
    bit            pend = 1'b0;
    bit            rst_prev = 1'b0, done_prev = 1'b0, start_acc_prev = 1'b0;
    int            ncyc = 0, last_wr = 0, last_pop = 0, run_cycles = 0, stuck_seen = 0;
    logic [DW-1:0] exp_cmd[NT];
    logic [DW-1:0] obs[3];
    logic [31:0]   lv;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (stuck_cnt != stuck_seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_bound: got no done, want done within budget");
            stuck_seen = stuck_cnt;
        end
        if (rst) begin
            if (rst_prev) begin
                chk("reset_flags", 64'({busy, done, success, timeout, bus.cmd_wr_en,
                                        bus.resp_rd_en}), 64'd0);
                chk("reset_stats", 64'({err_count, first_err_idx, bus.cmd_wr_data}), 64'd0);
            end
            wr_idx = 0; pop_idx = 0; chk_idx = 0; m_errs = 0; m_first = 0; pend = 1'b0;
            start_acc_prev = 1'b0;
        end else begin
            if (start_acc_prev) begin
                chk("first_issue", 64'({busy, bus.cmd_wr_en}), 64'({1'b1, !bus.cmd_full}));
            end
            start_acc_prev = 1'b0;
            if (pend) begin
                if (chk_idx < NT && bus.resp_rd_data != exp_cmd[chk_idx] + 1) begin
                    if (m_errs == 0) m_first = chk_idx;
                    m_errs++;
                end
                chk_idx++;
                pend = 1'b0;
            end
            if (bus.cmd_wr_en) begin
                chk("wr_while_full", 64'(bus.cmd_full), 64'd0);
                chk("outstanding_lt_max", 64'((wr_idx - pop_idx) < MO), 64'd1);
                if (wr_idx < NT) chk("cmd_data", 64'(bus.cmd_wr_data), 64'(exp_cmd[wr_idx]));
                else chk("extra_write", 64'(wr_idx), 64'(NT - 1));
                if (wr_idx < 3) obs[wr_idx] = bus.cmd_wr_data;
                wr_idx++;
                last_wr = ncyc;
            end
            if (bus.resp_rd_en) begin
                chk("rd_while_empty", 64'(bus.resp_empty), 64'd0);
                chk("pop_in_range", 64'(pop_idx < NT), 64'd1);
                pop_idx++;
                last_pop = ncyc;
                pend = 1'b1;
            end
            if (start && !busy) begin
                lv = SEED;
                for (int i = 0; i < NT; i++) begin
                    exp_cmd[i] = mode_lfsr ? lv[DW-1:0] : DW'(i);
                    lv = lfsr_step(lv);
                end
                wr_idx = 0; pop_idx = 0; chk_idx = 0; m_errs = 0; m_first = 0; pend = 1'b0;
                start_acc_prev = 1'b1;
            end
            if (done && !done_prev) begin
                chk("busy_in_done", 64'(busy), 64'd0);
                chk("timeout_flag", 64'(timeout), 64'(exp_timeout));
                chk("success", 64'(success), 64'((m_errs == 0) && !exp_timeout));
                chk("err_count", 64'(err_count), 64'(m_errs));
                if (m_errs != 0) chk("first_err_idx", 64'(first_err_idx), 64'(m_first));
                chk("write_count", 64'(wr_idx), 64'(exp_timeout ? MO : NT));
                if (exp_timeout) begin
                    chk("timeout_latency", 64'(ncyc - last_wr), 64'(TO + 1));
                end else begin
                    chk("done_latency", 64'(ncyc - last_pop), 64'd2);
                    chk("check_count", 64'(chk_idx), 64'(NT));
                end
                if (pin_errs >= 0) chk("pin_err_count", 64'(err_count), 64'(pin_errs));
                if (pin_first >= 0) chk("pin_first_err", 64'(first_err_idx), 64'(pin_first));
                if (pin_lfsr) begin
                    chk("pin_lfsr0", 64'(obs[0]), 64'h1);
                    chk("pin_lfsr1", 64'(obs[1]), 64'h3);
                    chk("pin_lfsr2", 64'(obs[2]), 64'h6);
                end
                if (pin_inc) begin
                    chk("pin_inc1", 64'(obs[1]), 64'h1);
                    chk("pin_inc2", 64'(obs[2]), 64'h2);
                end
            end
            run_cycles = busy ? run_cycles + 1 : 0;
        end
        rst_prev = rst;
        done_prev = done;
    end

    // ---------------- stimulus ----------------
    task automatic begin_run(input bit m, input int l, input bit d, input bit rs, input bit rf,
                             input logic [NT-1:0] mask, input bit eto, input int perr,
                             input int pfirst, input bit plfsr, input bit pinc);
        @(posedge clk); #1;
        lat = l; drop_resp = d; rand_stall = rs; rand_full = rf; corrupt_mask = mask;
        exp_timeout = eto; pin_errs = perr; pin_first = pfirst; pin_lfsr = plfsr;
        pin_inc = pinc; mode_lfsr = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 12000 && !got; k++) begin
            if (done) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) stuck_cnt++;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_wr(input int n);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            if (wr_idx >= n) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) stuck_cnt++;
    endtask

    logic [NT-1:0] rmask;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Incrementing, clean loopback.
        begin_run(1'b0, 10, 1'b0, 1'b0, 1'b0, '0, 1'b0, 0, -1, 1'b0, 1'b1);
        wait_done();
        // LFSR, clean loopback, restarted from DONE.
        begin_run(1'b1, 10, 1'b0, 1'b0, 1'b0, '0, 1'b0, 0, -1, 1'b1, 1'b0);
        wait_done();
        // No responses ever: outstanding limit then watchdog.
        begin_run(1'b0, 2, 1'b1, 1'b0, 1'b0, '0, 1'b1, 0, -1, 1'b0, 1'b0);
        wait_done();
        // cmd_full held for 50 cycles mid-run.
        begin_run(1'b0, 6, 1'b0, 1'b0, 1'b0, '0, 1'b0, 0, -1, 1'b0, 1'b0);
        wait_wr(5);
        force_full = 1'b1;
        repeat (50) @(posedge clk);
        #1 force_full = 1'b0;
        wait_done();
        // Responses 5 and 9 corrupted, then a clean rerun.
        begin_run(1'b0, 4, 1'b0, 1'b0, 1'b0, 16'h0220, 1'b0, 2, 5, 1'b0, 1'b0);
        wait_done();
        begin_run(1'b0, 4, 1'b0, 1'b0, 1'b0, '0, 1'b0, 0, -1, 1'b0, 1'b0);
        wait_done();
        // Reset mid-run, then a fresh LFSR run starts from the seed.
        begin_run(1'b1, 3, 1'b0, 1'b0, 1'b0, '0, 1'b0, -1, -1, 1'b0, 1'b0);
        wait_wr(7);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        begin_run(1'b1, 3, 1'b0, 1'b0, 1'b0, '0, 1'b0, 0, -1, 1'b1, 1'b0);
        wait_done();
        // Randomized runs with stalls, random full and random corruption.
        for (int r = 0; r < 6; r++) begin
            rmask = '0;
            if ($urandom_range(0, 1) == 1) rmask[$urandom_range(0, NT - 1)] = 1'b1;
            if ($urandom_range(0, 1) == 1) rmask[$urandom_range(0, NT - 1)] = 1'b1;
            begin_run(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)), 1'b0, 1'b1, 1'b1,
                      rmask, 1'b0, -1, -1, 1'b0, 1'b0);
            wait_done();
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cdc_traffic_checker.md
Name: cdc_traffic_checker

Overview:
- Parametrised successor to the fixed command/response test sequencer in the CDC system top.
- Runs in the command-side clock domain. Pushes NUM_TXN patterned commands into the command FIFO write port and pops the same number of responses from the response FIFO read port.
- Checks each response against an expected value regenerated locally, then reports pass/fail, error statistics and timeout.
- Adds the following, which the fixed sequencer lacks: selectable incrementing/LFSR pattern, an outstanding-transaction limit, an error counter with first-error index, a watchdog, and restart without reset.

Parameters:
- DATA_WIDTH, 32, command/response word width; legal range 8..32.
- NUM_TXN, 16, transactions per run; must be ≥1.
- CNT_W, 16, width of the transaction counters and first_err_idx; NUM_TXN must be < 2^CNT_W.
- MAX_OUTSTANDING, 8, maximum issued-but-not-popped transactions; must be ≥1.
- RESP_ADD, 1, expected response = command + RESP_ADD, mod 2^DATA_WIDTH.
- LFSR_SEED, 32'h0000_0001, nonzero seed for LFSR mode.
- TIMEOUT_CYCLES, 4096, number of cycles without progress before abort.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run.
- mode_lfsr  in  1  pattern select: 0 = incrementing, 1 = LFSR. Sampled when start is accepted.
- cmd_wr_en  out  1  command FIFO write strobe.
- cmd_wr_data  out  DATA_WIDTH  command word.
- cmd_full  in  1  command FIFO full flag.
- resp_rd_en  out  1  response FIFO read strobe.
- resp_rd_data  in  DATA_WIDTH  response word; valid one cycle after resp_rd_en.
- resp_empty  in  1  response FIFO empty flag.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE.
- success  out  1  valid when done is high.
- timeout  out  1  watchdog fired this run.
- err_count  out  16  mismatch count; saturates at 16'hFFFF.
- first_err_idx  out  CNT_W  index of the first mismatching response; meaningful only when err_count≠0.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0.
  - Counters, LFSRs and the watchdog are cleared.
  - Reset mid-run aborts immediately. External FIFOs are not flushed.
- States: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - DONE→RUN on start: clears stats, counters and pattern generators.
  - start is ignored in RUN.
- Pattern generation:
  - Incrementing mode: command i = i, zero-extended or truncated to DATA_WIDTH.
  - LFSR mode: 32-bit Fibonacci LFSR, shift left, feedback = b31^b21^b1^b0 into b0, loaded with LFSR_SEED at start. The command is the low DATA_WIDTH bits; the LFSR advances once per accepted write.
  - Expected-value generator: an identical second generator advancing once per checked response. No per-transaction storage.
- Issue (combinational): cmd_wr_en = RUN && issued<NUM_TXN && !cmd_full && (issued−popped)<MAX_OUTSTANDING. Every asserted strobe is a completed write.
- Pop (combinational): resp_rd_en = RUN && popped<NUM_TXN && !resp_empty.
- Check pipeline:
  - rd_valid register = resp_rd_en delayed one cycle.
  - On rd_valid, compare resp_rd_data against expected + RESP_ADD.
  - On mismatch: err_count increments (saturating); first_err_idx captures the check index on the first mismatch only.
  - checked increments on each rd_valid.
- Simultaneous write and pop in the same cycle are allowed; outstanding is unchanged.
- Watchdog:
  - Counter clears on any cycle with cmd_wr_en or resp_rd_en, and counts otherwise in RUN.
  - On reaching TIMEOUT_CYCLES: timeout=1 and go to DONE, even with a check in flight; an in-flight check is discarded.
- Completion: when checked==NUM_TXN, go to DONE.
- DONE outputs:
  - busy=0, done=1.
  - success = (err_count==0) && !timeout.
  - All stats hold until the next start or rst.
- Latency:
  - First cmd_wr_en occurs the cycle after start is sampled.
  - done rises the cycle after the last check.

Test Plan:
- Increment mode, NUM_TXN=16, loopback model returns cmd+1 after 10 cycles → cmd writes 0x0..0xF in order, done=1, success=1, err_count=0, timeout=0.
- LFSR mode, seed 1 → first three commands 0x00000001, 0x00000003, 0x00000006; loopback passes → success=1.
- Model never returns responses, MAX_OUTSTANDING=8 → exactly 8 writes, then after 4096 idle cycles timeout=1, done=1, success=0.
- cmd_full held high for 50 cycles mid-run → no cmd_wr_en during that window, no timeout, run completes with success=1.
- Model corrupts responses 5 and 9 (bit 0 flipped) → err_count=2, first_err_idx=5, success=0. A second start with a clean model → err_count=0, success=1.
- rst asserted at transaction 7, then start → all outputs 0 the cycle after rst; the new run issues from command 0 (incrementing) or the seed (LFSR).
